iir_iq_sched: RTL and testbench
===============================

Name: iir_iq_sched

Overview:
- Scheduler that time-shares one external biquad MAC engine between the I and Q channels.
- Each accepted I/Q sample pair is pushed through NSEC cascaded sections: all I sections first, then all Q sections.
- Sits between the ADC/decimation front end and the downstream sync blocks. It replaces two parallel IIR instances with one shared engine plus this sequencer.

Parameters:
- IN_WID, 10, signed input sample width
- OUT_WID, 10, signed output sample width
- DAT_WID, 14, engine data width (DAT_WID >= IN_WID, DAT_WID >= OUT_WID)
- NSEC, 3, number of cascaded biquad sections (1..15)
- TMO_CYC, 64, max cycles to wait for eng_done before abort

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample pair valid
- in_ready  out  1  scheduler can accept a pair
- data_I_in  in  IN_WID  signed I sample
- data_Q_in  in  IN_WID  signed Q sample
- eng_start  out  1  one-cycle engine request pulse
- eng_chan  out  1  0=I state bank, 1=Q state bank
- eng_sec  out  4  section index
- eng_x  out  DAT_WID  section input
- eng_done  in  1  engine result valid
- eng_y  in  DAT_WID  section output
- data_I_o  out  OUT_WID  filtered I
- data_Q_o  out  OUT_WID  filtered Q
- out_valid  out  1  one-cycle pulse, outputs updated
- err  out  1  sticky engine timeout flag

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset values: in_ready=1, eng_start=0, eng_chan=0, eng_sec=0, eng_x=0, data_I_o=0, data_Q_o=0, out_valid=0, err=0. State returns to IDLE.
- State machine: IDLE -> ISSUE -> WAIT -> (ISSUE | IDLE).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch both inputs sign-extended to DAT_WID; set chan=0, sec=0, eng_x=I; go ISSUE.
- ISSUE:
  - eng_start=1 for exactly one cycle; eng_chan, eng_sec, eng_x stable.
  - Clear timeout counter; go WAIT.
- WAIT (eng_chan/eng_sec/eng_x held):
  - On eng_done, latch eng_y.
  - If sec<NSEC-1: sec+1, eng_x=eng_y, go ISSUE.
  - Else if chan=0: I result = sat(eng_y); chan=1, sec=0, eng_x=latched Q; go ISSUE.
  - Else: Q result = sat(eng_y); go IDLE.
- Output update: data_I_o and data_Q_o update together on the cycle after the final Q eng_done. out_valid pulses that same cycle and in_ready returns to 1 that same cycle. Outputs hold between updates.
- Saturation: sat() clamps signed DAT_WID to signed OUT_WID range [-2^(OUT_WID-1), 2^(OUT_WID-1)-1]. No shift, no rounding.
- Latency: engine latency L (done L cycles after start, L>=1). Accept cycle to out_valid = 1 + 2*NSEC*(1+L) cycles. Back-to-back throughput is one pair per 1 + 2*NSEC*(1+L) cycles.
- in_ready is 0 in ISSUE and WAIT. in_valid is ignored there; the upstream source must hold its data.
- eng_done outside WAIT (late or spurious) is ignored.
- Timeout: TMO_CYC cycles in WAIT without eng_done causes:
  - err=1, sticky until reset;
  - current pair discarded, no out_valid;
  - outputs unchanged;
  - state goes to IDLE.
- Reset mid-operation: immediate return to reset values; the partial pair is lost. No eng_start after reset until a new pair is accepted.

Optional Feature:
- Macro: IIR_SCHED_SETTLE_EN.
- Defined: adds parameter SETTLE_N (default 8) and a saturating count of completed pairs since reset.
  - out_valid is suppressed for the first SETTLE_N completed pairs; data_I_o/data_Q_o still update.
  - Timed-out pairs do not count.
- Undefined: out_valid pulses for every completed pair; no counter logic.

Test Plan:
- Engine model L=2, eng_y=eng_x+1, NSEC=3; accept I=5, Q=-3 at cycle 0.
  - Required: out_valid at cycle 19 only; data_I_o=8, data_Q_o=0.
  - Required: eng_start pulses at cycles 1,4,...,16; eng_chan=1 from cycle 10.
  - Required: in_ready=0 for cycles 1-18.
- Saturation: engine returns +600 on I and -700 on Q final section, OUT_WID=10 -> data_I_o=511, data_Q_o=-512.
- Timeout: engine never asserts eng_done -> err=1 after 64 WAIT cycles; in_ready=1 next cycle; no out_valid; outputs keep their prior values. A following pair completes normally and err stays 1.
- Spurious/late done: eng_done pulsed in IDLE and 5 cycles after an already-served done -> no state change, no extra out_valid, results identical to the first test.
- Reset mid-op: reset_n low during WAIT of Q section 1 -> all outputs 0 while low. After release, in_ready=1, eng_start=0 until the next in_valid.
- IIR_SCHED_SETTLE_EN, SETTLE_N=4: 5 pairs -> out_valid only for pair 5; data_I_o updated on every pair.

Source files
------------

// File: rtl/iir_iq_sched.sv
// Sequencer sharing one external biquad MAC engine between I and Q: all I sections, then all Q sections.
// Optional macro IIR_SCHED_SETTLE_EN suppresses out_valid for the first SETTLE_N completed pairs.
module iir_iq_sched #(
    parameter int IN_WID  = 10,
    parameter int OUT_WID = 10,
    parameter int DAT_WID = 14,
    parameter int NSEC    = 3,
    parameter int TMO_CYC = 64
`ifdef IIR_SCHED_SETTLE_EN
    ,
    parameter int SETTLE_N = 8
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_WID-1:0]  data_I_in,
    input  logic signed [IN_WID-1:0]  data_Q_in,
    output logic                      eng_start,
    output logic                      eng_chan,
    output logic [3:0]                eng_sec,
    output logic signed [DAT_WID-1:0] eng_x,
    input  logic                      eng_done,
    input  logic signed [DAT_WID-1:0] eng_y,
    output logic signed [OUT_WID-1:0] data_I_o,
    output logic signed [OUT_WID-1:0] data_Q_o,
    output logic                      out_valid,
    output logic                      err
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic signed [DAT_WID-1:0] SAT_MAX = DAT_WID'((2 ** (OUT_WID - 1)) - 1);
    localparam logic signed [DAT_WID-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                     state, state_nxt;
    logic                       chan_q;
    logic [3:0]                 sec_q;
    logic signed [DAT_WID-1:0]  x_q;
    logic signed [DAT_WID-1:0]  q_lat;
    logic signed [OUT_WID-1:0]  res_i;
    logic [TMO_W-1:0]           tmo_cnt;
    logic                       last_sec;
    logic                       tmo_hit;
    logic                       pair_done;
    logic                       settled;

    function automatic logic signed [OUT_WID-1:0] sat(input logic signed [DAT_WID-1:0] v);
        logic signed [DAT_WID-1:0] c;
        if (v > SAT_MAX)
            c = SAT_MAX;
        else if (v < SAT_MIN)
            c = SAT_MIN;
        else
            c = v;
        return c[OUT_WID-1:0];
    endfunction

    assign last_sec  = (sec_q == 4'(NSEC - 1));
    assign tmo_hit   = (state == WAIT) && !eng_done && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    assign pair_done = (state == WAIT) && eng_done && last_sec && chan_q;

    assign eng_chan = chan_q;
    assign eng_sec  = sec_q;
    assign eng_x    = x_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        eng_start = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (pair_done || tmo_hit)
                    state_nxt = IDLE;
                else if (eng_done)
                    state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Engine result becomes the next section's input; I result waits in res_i until Q finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_q    <= 1'b0;
            sec_q     <= 4'd0;
            x_q       <= '0;
            q_lat     <= '0;
            res_i     <= '0;
            tmo_cnt   <= '0;
            data_I_o  <= '0;
            data_Q_o  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= DAT_WID'(data_I_in);
                        q_lat  <= DAT_WID'(data_Q_in);
                        chan_q <= 1'b0;
                        sec_q  <= 4'd0;
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    if (eng_done) begin
                        if (!last_sec) begin
                            sec_q <= sec_q + 4'd1;
                            x_q   <= eng_y;
                        end else if (!chan_q) begin
                            res_i  <= sat(eng_y);
                            chan_q <= 1'b1;
                            sec_q  <= 4'd0;
                            x_q    <= q_lat;
                        end else begin
                            data_I_o  <= res_i;
                            data_Q_o  <= sat(eng_y);
                            out_valid <= settled;
                        end
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IIR_SCHED_SETTLE_EN
    localparam int SET_W = $clog2(SETTLE_N + 1);
    logic [SET_W-1:0] pair_cnt;

    // Saturating count of completed pairs; timed-out pairs never reach pair_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pair_cnt <= '0;
        else if (pair_done && !settled)
            pair_cnt <= pair_cnt + SET_W'(1);
    end

    assign settled = (pair_cnt == SET_W'(SETTLE_N));
`else
    assign settled = 1'b1;
`endif

endmodule

// File: tb/tb_iir_iq_sched.sv
// Self-checking bench for iir_iq_sched: behavioural engine model (latency LAT, y = x + 1) plus an expected-result queue.
module tb_iir_iq_sched;

    localparam int IN_WID  = 10;
    localparam int OUT_WID = 10;
    localparam int DAT_WID = 14;
    localparam int NSEC    = 3;
    localparam int TMO_CYC = 64;
    localparam int LAT     = 2;
`ifdef IIR_SCHED_SETTLE_EN
    localparam int SETTLE_N = 4;
`endif
    localparam logic [42:0] RST_VEC = {1'b1, 42'd0};

    typedef struct packed {
        logic signed [OUT_WID-1:0] i;
        logic signed [OUT_WID-1:0] q;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [IN_WID-1:0]  data_I_in = '0;
    logic signed [IN_WID-1:0]  data_Q_in = '0;
    logic                      eng_start;
    logic                      eng_chan;
    logic [3:0]                eng_sec;
    logic signed [DAT_WID-1:0] eng_x;
    logic                      eng_done;
    logic signed [DAT_WID-1:0] eng_y;
    logic signed [OUT_WID-1:0] data_I_o;
    logic signed [OUT_WID-1:0] data_Q_o;
    logic                      out_valid;
    logic                      err;

    logic                      model_done = 1'b0;
    logic signed [DAT_WID-1:0] model_y = '0;
    logic                      spur_done = 1'b0;
    logic                      eng_mute = 1'b0;
    logic                      sat_mode = 1'b0;
    int                        pend = 0;
    logic signed [DAT_WID-1:0] px = '0;
    logic                      pc = 1'b0;
    logic [3:0]                ps = '0;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic signed [OUT_WID-1:0] last_i = '0;
    logic signed [OUT_WID-1:0] last_q = '0;

    assign eng_done = model_done | spur_done;
    assign eng_y    = spur_done ? 14'sd100 : model_y;

    iir_iq_sched #(
        .IN_WID(IN_WID), .OUT_WID(OUT_WID), .DAT_WID(DAT_WID), .NSEC(NSEC), .TMO_CYC(TMO_CYC)
`ifdef IIR_SCHED_SETTLE_EN
        , .SETTLE_N(SETTLE_N)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_I_in(data_I_in), .data_Q_in(data_Q_in), .eng_start(eng_start),
        .eng_chan(eng_chan), .eng_sec(eng_sec), .eng_x(eng_x), .eng_done(eng_done),
        .eng_y(eng_y), .data_I_o(data_I_o), .data_Q_o(data_Q_o),
        .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Engine model: done is high for one cycle, LAT cycles after the start cycle.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (pend == 1 && !eng_mute) begin
            model_done <= 1'b1;
            if (sat_mode && ps == 4'(NSEC - 1))
                model_y <= pc ? -14'sd700 : 14'sd600;
            else
                model_y <= px + 14'sd1;
        end
        if (pend > 0)
            pend <= pend - 1;
        if (eng_start) begin
            pend <= LAT - 1;
            px   <= eng_x;
            pc   <= eng_chan;
            ps   <= eng_sec;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic signed [OUT_WID-1:0] sat_ref(input int v);
        if (v > 511)
            return 10'sd511;
        if (v < -512)
            return 10'h200;
        return 10'(v);
    endfunction

    // Presents a pair in IDLE and returns at the negedge of cycle 1 (the cycle after acceptance).
    task automatic send_pair(input logic signed [IN_WID-1:0] i, input logic signed [IN_WID-1:0] q);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL accept_ready: in_ready=%b, required 1", in_ready);
        end
        data_I_in = i;
        data_Q_in = q;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int k = 0; k < budget; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({in_ready, eng_start, eng_chan, eng_sec, eng_x, data_I_o, data_Q_o, out_valid, err} !== RST_VEC) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h, required %h",
                     {in_ready, eng_start, eng_chan, eng_sec, eng_x, data_I_o, data_Q_o, out_valid, err}, RST_VEC);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({in_ready, eng_start, out_valid} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: ready/start/valid=%b, required 100", {in_ready, eng_start, out_valid});
        end
    endtask

`ifdef IIR_SCHED_SETTLE_EN
    task automatic test_settle();
        int early;
        for (int p = 1; p <= 5; p++) begin
            early = 0;
            send_pair(10'(p), 10'(-p));
            for (int c = 1; c < 19; c++) begin
                if (out_valid === 1'b1)
                    early++;
                @(negedge clk);
            end
            n_tests += 3;
            if (early != 0) begin
                n_fail++;
                $display("[TB] FAIL settle_early_valid: pair %0d saw %0d pulses, required 0", p, early);
            end
            if (out_valid !== (p == 5)) begin
                n_fail++;
                $display("[TB] FAIL settle_valid: pair %0d out_valid=%b, required %b", p, out_valid, p == 5);
            end
            if (data_I_o !== sat_ref(p + NSEC)) begin
                n_fail++;
                $display("[TB] FAIL settle_data_I: pair %0d got %0d, required %0d", p, data_I_o, sat_ref(p + NSEC));
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_basic();
        exp_t e;
        bit   issue;
        int   idx;
        int   exp_x;
        exp_q.push_back('{i: sat_ref(5 + NSEC), q: sat_ref(-3 + NSEC)});
        send_pair(10'sd5, -10'sd3);
        for (int c = 1; c <= 22; c++) begin
            issue = (c <= 16) && ((c - 1) % 3 == 0);
            idx   = (c - 1) / 3;
            n_tests += 3;
            if (eng_start !== issue) begin
                n_fail++;
                $display("[TB] FAIL basic_start: cycle %0d got %b, required %b", c, eng_start, issue);
            end
            if (in_ready !== (c >= 19)) begin
                n_fail++;
                $display("[TB] FAIL basic_ready: cycle %0d got %b, required %b", c, in_ready, c >= 19);
            end
            if (out_valid !== (c == 19)) begin
                n_fail++;
                $display("[TB] FAIL basic_valid: cycle %0d got %b, required %b", c, out_valid, c == 19);
            end
            if (c <= 18) begin
                n_tests++;
                if (eng_chan !== (c >= 10)) begin
                    n_fail++;
                    $display("[TB] FAIL basic_chan: cycle %0d got %b, required %b", c, eng_chan, c >= 10);
                end
            end
            if (issue) begin
                exp_x = (idx < NSEC) ? 5 + idx : -3 + idx - NSEC;
                n_tests += 2;
                if (eng_sec !== 4'(idx % NSEC)) begin
                    n_fail++;
                    $display("[TB] FAIL basic_sec: cycle %0d got %0d, required %0d", c, eng_sec, idx % NSEC);
                end
                if (eng_x !== 14'(exp_x)) begin
                    n_fail++;
                    $display("[TB] FAIL basic_x: cycle %0d got %0d, required %0d", c, eng_x, exp_x);
                end
            end
            if (c == 19) begin
                n_tests += 2;
                if (exp_q.size() == 0) begin
                    n_fail += 2;
                    $display("[TB] FAIL basic_data: no expected entry queued");
                end else begin
                    e = exp_q.pop_front();
                    last_i = e.i;
                    last_q = e.q;
                    if (data_I_o !== e.i) begin
                        n_fail++;
                        $display("[TB] FAIL basic_data_I: got %0d, required %0d", data_I_o, e.i);
                    end
                    if (data_Q_o !== e.q) begin
                        n_fail++;
                        $display("[TB] FAIL basic_data_Q: got %0d, required %0d", data_Q_o, e.q);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_spurious();
        exp_t e;
        int   ov_cnt;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        n_tests++;
        if ({in_ready, eng_start, out_valid} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL spur_idle: ready/start/valid=%b, required 100", {in_ready, eng_start, out_valid});
        end
        exp_q.push_back('{i: sat_ref(5 + NSEC), q: sat_ref(-3 + NSEC)});
        send_pair(10'sd5, -10'sd3);
        ov_cnt = 0;
        for (int c = 1; c <= 26; c++) begin
            spur_done = (c == 4) || (c == 23);
            if (out_valid === 1'b1)
                ov_cnt++;
            if (c == 19) begin
                n_tests += 2;
                if (exp_q.size() == 0) begin
                    n_fail += 2;
                    $display("[TB] FAIL spur_data: no expected entry queued");
                end else begin
                    e = exp_q.pop_front();
                    if (data_I_o !== e.i) begin
                        n_fail++;
                        $display("[TB] FAIL spur_data_I: got %0d, required %0d", data_I_o, e.i);
                    end
                    if (data_Q_o !== e.q) begin
                        n_fail++;
                        $display("[TB] FAIL spur_data_Q: got %0d, required %0d", data_Q_o, e.q);
                    end
                end
            end
            @(negedge clk);
        end
        spur_done = 1'b0;
        n_tests += 2;
        if (ov_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL spur_valid_count: got %0d, required 1", ov_cnt);
        end
        if ({data_I_o, data_Q_o} !== {last_i, last_q}) begin
            n_fail++;
            $display("[TB] FAIL spur_hold: got %0d/%0d, required %0d/%0d", data_I_o, data_Q_o, last_i, last_q);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        bit   seen;
        int   waited;
        sat_mode = 1'b1;
        exp_q.push_back('{i: sat_ref(600), q: sat_ref(-700)});
        send_pair(10'sd5, -10'sd3);
        wait_valid(40, seen, waited);
        n_tests += 2;
        if (!seen || exp_q.size() == 0) begin
            n_fail += 2;
            $display("[TB] FAIL sat_valid: out_valid seen=%b, required 1", seen);
        end else begin
            e = exp_q.pop_front();
            last_i = e.i;
            last_q = e.q;
            if (data_I_o !== e.i) begin
                n_fail++;
                $display("[TB] FAIL sat_data_I: got %0d, required %0d", data_I_o, e.i);
            end
            if (data_Q_o !== e.q) begin
                n_fail++;
                $display("[TB] FAIL sat_data_Q: got %0d, required %0d", data_Q_o, e.q);
            end
        end
        sat_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ov_seen;
        bit   seen;
        int   waited;
        eng_mute = 1'b1;
        ov_seen  = 1'b0;
        send_pair(10'sd7, 10'sd7);
        for (int c = 1; c <= 66; c++) begin
            if (out_valid === 1'b1)
                ov_seen = 1'b1;
            if (c == 65) begin
                n_tests++;
                if ({err, in_ready} !== 2'b00) begin
                    n_fail++;
                    $display("[TB] FAIL tmo_before: err/ready=%b, required 00", {err, in_ready});
                end
            end
            if (c == 66) begin
                n_tests += 2;
                if ({err, in_ready} !== 2'b11) begin
                    n_fail++;
                    $display("[TB] FAIL tmo_after: err/ready=%b, required 11", {err, in_ready});
                end
                if ({data_I_o, data_Q_o} !== {last_i, last_q}) begin
                    n_fail++;
                    $display("[TB] FAIL tmo_hold: got %0d/%0d, required %0d/%0d", data_I_o, data_Q_o, last_i, last_q);
                end
            end
            if (c < 66)
                @(negedge clk);
        end
        n_tests++;
        if (ov_seen) begin
            n_fail++;
            $display("[TB] FAIL tmo_no_valid: out_valid seen=1, required 0");
        end
        eng_mute = 1'b0;
        exp_q.push_back('{i: sat_ref(10 + NSEC), q: sat_ref(-10 + NSEC)});
        send_pair(10'sd10, -10'sd10);
        wait_valid(40, seen, waited);
        n_tests += 3;
        if (!seen || exp_q.size() == 0) begin
            n_fail += 2;
            $display("[TB] FAIL tmo_next_valid: out_valid seen=%b, required 1", seen);
        end else begin
            e = exp_q.pop_front();
            last_i = e.i;
            last_q = e.q;
            if (data_I_o !== e.i) begin
                n_fail++;
                $display("[TB] FAIL tmo_next_I: got %0d, required %0d", data_I_o, e.i);
            end
            if (data_Q_o !== e.q) begin
                n_fail++;
                $display("[TB] FAIL tmo_next_Q: got %0d, required %0d", data_Q_o, e.q);
            end
        end
        if (err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL tmo_sticky: err=%b, required 1", err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ov_cnt;
        exp_q.push_back('{i: sat_ref(20 + NSEC), q: sat_ref(30 + NSEC)});
        exp_q.push_back('{i: sat_ref(-40 + NSEC), q: sat_ref(-50 + NSEC)});
        @(negedge clk);
        data_I_in = 10'sd20;
        data_Q_in = 10'sd30;
        in_valid  = 1'b1;
        @(negedge clk);
        data_I_in = -10'sd40;
        data_Q_in = -10'sd50;
        ov_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 20) begin
                in_valid = 1'b0;
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_second_accept: in_ready=%b at cycle 20, required 0", in_ready);
                end
            end
            if (out_valid === 1'b1)
                ov_cnt++;
            if (c == 19 || c == 38) begin
                n_tests += 3;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_valid: cycle %0d out_valid=%b, required 1", c, out_valid);
                end
                if (exp_q.size() == 0) begin
                    n_fail += 2;
                    $display("[TB] FAIL b2b_data: no expected entry queued at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    last_i = e.i;
                    last_q = e.q;
                    if (data_I_o !== e.i) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_data_I: cycle %0d got %0d, required %0d", c, data_I_o, e.i);
                    end
                    if (data_Q_o !== e.q) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_data_Q: cycle %0d got %0d, required %0d", c, data_Q_o, e.q);
                    end
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (ov_cnt != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_valid_count: got %0d, required 2", ov_cnt);
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bit   seen;
        int   waited;
        send_pair(10'sd1, 10'sd2);
        for (int c = 1; c < 14; c++)
            @(negedge clk);
        n_tests++;
        if ({eng_chan, eng_sec, in_ready} !== 6'b1_0001_0) begin
            n_fail++;
            $display("[TB] FAIL midop_position: chan/sec/ready=%b, required 1_0001_0", {eng_chan, eng_sec, in_ready});
        end
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({in_ready, eng_start, eng_chan, eng_sec, eng_x, data_I_o, data_Q_o, out_valid, err} !== RST_VEC) begin
                n_fail++;
                $display("[TB] FAIL midop_reset_values: step %0d got %h, required %h", k,
                         {in_ready, eng_start, eng_chan, eng_sec, eng_x, data_I_o, data_Q_o, out_valid, err}, RST_VEC);
            end
            @(negedge clk);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if ({in_ready, eng_start, out_valid} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL midop_after_release: step %0d ready/start/valid=%b, required 100", k,
                         {in_ready, eng_start, out_valid});
            end
        end
        exp_q.push_back('{i: sat_ref(0 + NSEC), q: sat_ref(2 + NSEC)});
        send_pair(10'sd0, 10'sd2);
        wait_valid(40, seen, waited);
        n_tests += 3;
        if (!seen || exp_q.size() == 0) begin
            n_fail += 3;
            $display("[TB] FAIL midop_recover_valid: out_valid seen=%b, required 1", seen);
        end else begin
            e = exp_q.pop_front();
            if (waited != 18) begin
                n_fail++;
                $display("[TB] FAIL midop_latency: out_valid at cycle %0d, required 19", waited + 1);
            end
            if (data_I_o !== e.i) begin
                n_fail++;
                $display("[TB] FAIL midop_recover_I: got %0d, required %0d", data_I_o, e.i);
            end
            if (data_Q_o !== e.q) begin
                n_fail++;
                $display("[TB] FAIL midop_recover_Q: got %0d, required %0d", data_Q_o, e.q);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef IIR_SCHED_SETTLE_EN
        test_settle();
`endif
        test_basic();
        test_spurious();
        test_saturation();
        test_timeout();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
